// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the parametrised UART receiver.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP1,
    ST_STOP2,
    ST_BREAK
  } rx_state_e;

  localparam logic [2:0] PAR_NONE  = 3'd0;
  localparam logic [2:0] PAR_EVEN  = 3'd1;
  localparam logic [2:0] PAR_ODD   = 3'd2;
  localparam logic [2:0] PAR_MARK  = 3'd3;
  localparam logic [2:0] PAR_SPACE = 3'd4;

  // Majority of three samples.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_param_if.sv
// Receive-word handshake between the UART receiver and its consumer.
interface uart_rx_param_if #(
  parameter int MAX_BITS = 9
);
  logic [MAX_BITS-1:0] rx_data;
  logic                rx_valid;
  logic                rx_ready;
  logic                rx_par_err;
  logic                rx_frm_err;
  logic                rx_brk;
  logic                rx_ovr;

  modport master (
    output rx_data, rx_valid, rx_par_err, rx_frm_err, rx_brk, rx_ovr,
    input  rx_ready
  );

  modport slave (
    input  rx_data, rx_valid, rx_par_err, rx_frm_err, rx_brk, rx_ovr,
    output rx_ready
  );
endinterface

// File: rtl/uart_rx_sampler.sv
// Input synchroniser, mid-bit 3-sample majority vote and start detection.
module uart_rx_sampler
  import uart_rx_pkg::*;
#(
  parameter int OVS         = 16,
  parameter int SYNC_STAGES = 2,
  localparam int CNT_W      = $clog2(OVS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             baud_en,
  input  logic             rx_i,
  input  logic [CNT_W-1:0] tick,
  output logic             bit_val,
  output logic             vote_vld,
  output logic             start
);

  localparam logic [CNT_W-1:0] T_A = CNT_W'(OVS/2 - 1);
  localparam logic [CNT_W-1:0] T_B = CNT_W'(OVS/2);
  localparam logic [CNT_W-1:0] T_C = CNT_W'(OVS/2 + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;
  logic                   smp_p0;
  logic                   smp_p1;

  // Synchroniser chain, idles high so reset looks like an idle line.
  always_ff @(posedge clk) begin
    if (rst) sync_q <= '1;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
  end

  assign rx_s = sync_q[SYNC_STAGES-1];

  // --- sample stage: capture the two early mid-bit samples ---
  always_ff @(posedge clk) begin
    if (baud_en && tick == T_A) smp_p0 <= rx_s;
    if (baud_en && tick == T_B) smp_p1 <= rx_s;
  end

  // --- vote stage: third sample is the live synced line ---
  assign bit_val  = maj3(smp_p0, smp_p1, rx_s);
  assign vote_vld = baud_en && (tick == T_C);
  // A low line on an enable cycle; the FSM only acts on it in IDLE, and
  // in BREAK its absence means the line has returned high.
  assign start    = baud_en && !rx_s;

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: configurable width, parity, stop bits,
// break detection and a valid/ready holding register with overrun flag.
module uart_rx_param
  import uart_rx_pkg::*;
#(
  parameter int OVS         = 16,
  parameter int MAX_BITS    = 9,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       baud_en,
  input  logic       rx_i,
  input  logic [3:0] cfg_bits,
  input  logic [2:0] cfg_par,
  input  logic       cfg_stop2,
  uart_rx_param_if.master rx_if,
  output logic       busy
);

  localparam int               CNT_W  = $clog2(OVS);
  localparam logic [CNT_W-1:0] T_LAST = CNT_W'(OVS - 1);
  localparam logic [3:0]       MAXB   = 4'(MAX_BITS);

  rx_state_e           state;
  logic [CNT_W-1:0]    tick;
  logic [3:0]          bit_idx;
  logic [3:0]          nbits;
  logic [2:0]          par_mode;
  logic                stop2;
  logic [MAX_BITS-1:0] shreg;
  logic [MAX_BITS-1:0] data_just;
  logic                par_err;
  logic                frm_err;
  logic                any_one;

  logic                bit_val;
  logic                vote_vld;
  logic                start;
  logic                done;
  logic                is_brk;
  logic                fin_frm;
  logic                exp_par;

  logic [MAX_BITS-1:0] out_data;
  logic                out_vld;
  logic                out_par;
  logic                out_frm;
  logic                out_brk;
  logic                out_ovr;

  function automatic logic [3:0] clamp_bits(input logic [3:0] b);
    if (b < 4'd5) return 4'd5;
    if (b > MAXB) return MAXB;
    return b;
  endfunction

  function automatic logic [2:0] norm_par(input logic [2:0] p);
    return (p > PAR_SPACE) ? PAR_NONE : p;
  endfunction

  uart_rx_sampler #(
    .OVS         (OVS),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sampler (
    .clk      (clk),
    .rst      (rst),
    .baud_en  (baud_en),
    .rx_i     (rx_i),
    .tick     (tick),
    .bit_val  (bit_val),
    .vote_vld (vote_vld),
    .start    (start)
  );

  // Bits arrive LSB first into the top of the register; shift down to
  // right-justify whatever width was latched for this frame.
  assign data_just = shreg >> (MAXB - nbits);

  // Expected parity bit for the latched mode.
  always_comb begin
    exp_par = 1'b0;
    case (par_mode)
      PAR_EVEN: exp_par = ^data_just;
      PAR_ODD:  exp_par = ~(^data_just);
      PAR_MARK: exp_par = 1'b1;
      default:  exp_par = 1'b0;
    endcase
  end

  // Frame completes on the mid-bit vote of the last stop bit.
  always_comb begin
    done = 1'b0;
    if (vote_vld) begin
      if (state == ST_STOP1 && !stop2) done = 1'b1;
      if (state == ST_STOP2)           done = 1'b1;
    end
  end

  assign is_brk  = ~any_one & ~bit_val;
  assign fin_frm = frm_err | ~bit_val;
  assign busy    = (state != ST_IDLE);

  // Frame sequencer; everything advances only on baud_en.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      tick    <= '0;
      bit_idx <= '0;
    end else if (baud_en) begin
      tick <= (tick == T_LAST) ? '0 : tick + 1'b1;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state    <= ST_START;
            tick     <= '0;
            bit_idx  <= '0;
            nbits    <= clamp_bits(cfg_bits);
            par_mode <= norm_par(cfg_par);
            stop2    <= cfg_stop2;
            par_err  <= 1'b0;
            frm_err  <= 1'b0;
            any_one  <= 1'b0;
          end
        end
        ST_START: begin
          if (vote_vld && bit_val) state <= ST_IDLE;
          else if (tick == T_LAST) state <= ST_DATA;
        end
        ST_DATA: begin
          if (vote_vld) begin
            shreg   <= {bit_val, shreg[MAX_BITS-1:1]};
            bit_idx <= bit_idx + 4'd1;
            any_one <= any_one | bit_val;
          end
          if (tick == T_LAST && bit_idx == nbits)
            state <= (par_mode != PAR_NONE) ? ST_PARITY : ST_STOP1;
        end
        ST_PARITY: begin
          if (vote_vld) begin
            par_err <= (bit_val != exp_par);
            any_one <= any_one | bit_val;
          end
          if (tick == T_LAST) state <= ST_STOP1;
        end
        ST_STOP1: begin
          if (vote_vld) begin
            frm_err <= fin_frm;
            any_one <= any_one | bit_val;
            if (!stop2) state <= is_brk ? ST_BREAK : ST_IDLE;
          end else if (tick == T_LAST && stop2) begin
            state <= ST_STOP2;
          end
        end
        ST_STOP2: begin
          if (vote_vld) state <= is_brk ? ST_BREAK : ST_IDLE;
        end
        ST_BREAK: begin
          if (!start) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Holding register: load on completion if free or draining, else flag overrun.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld  <= 1'b0;
      out_data <= '0;
      out_par  <= 1'b0;
      out_frm  <= 1'b0;
      out_brk  <= 1'b0;
      out_ovr  <= 1'b0;
    end else if (done && (!out_vld || rx_if.rx_ready)) begin
      out_vld  <= 1'b1;
      out_data <= is_brk ? '0 : data_just;
      out_par  <= par_err;
      out_frm  <= fin_frm;
      out_brk  <= is_brk;
      out_ovr  <= 1'b0;
    end else if (done) begin
      out_ovr  <= 1'b1;
    end else if (out_vld && rx_if.rx_ready) begin
      out_vld  <= 1'b0;
      out_par  <= 1'b0;
      out_frm  <= 1'b0;
      out_brk  <= 1'b0;
      out_ovr  <= 1'b0;
    end
  end

  assign rx_if.rx_data    = out_data;
  assign rx_if.rx_valid   = out_vld;
  assign rx_if.rx_par_err = out_par;
  assign rx_if.rx_frm_err = out_frm;
  assign rx_if.rx_brk     = out_brk;
  assign rx_if.rx_ovr     = out_ovr;

endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard bench for uart_rx_param: frames are driven bit-serially,
// expected words are queued at send time and matched when accepted.
module tb_uart_rx_param;

  localparam int OVS      = 16;
  localparam int MAX_BITS = 9;
  localparam int BDIV     = 4;
  localparam int BT       = OVS * BDIV;
  localparam int TMO      = 6 * BT;

  logic       clk = 1'b0;
  logic       rst;
  logic       baud_en;
  logic       rx_i;
  logic [3:0] cfg_bits;
  logic [2:0] cfg_par;
  logic       cfg_stop2;
  logic       busy;

  uart_rx_param_if #(.MAX_BITS(MAX_BITS)) rx_if ();

  uart_rx_param #(
    .OVS         (OVS),
    .MAX_BITS    (MAX_BITS),
    .SYNC_STAGES (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .baud_en   (baud_en),
    .rx_i      (rx_i),
    .cfg_bits  (cfg_bits),
    .cfg_par   (cfg_par),
    .cfg_stop2 (cfg_stop2),
    .rx_if     (rx_if),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // {data, par_err, frm_err, brk, ovr}
  typedef struct packed {
    logic [8:0] d;
    logic       p;
    logic       f;
    logic       b;
    logic       o;
  } exp_t;

  exp_t sb[$];
  exp_t mon_got;
  exp_t mon_want;
  int   checks = 0;
  int   errors = 0;

  initial begin
    baud_en = 1'b0;
    forever begin
      repeat (BDIV - 1) @(negedge clk);
      baud_en = 1'b1;
      @(negedge clk);
      baud_en = 1'b0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1);
  end

  // Compare every accepted word against the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && rx_if.rx_valid && rx_if.rx_ready) begin
      mon_got = {rx_if.rx_data, rx_if.rx_par_err, rx_if.rx_frm_err, rx_if.rx_brk, rx_if.rx_ovr};
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL word_unexpected got data=%h p%b f%b b%b o%b required none",
                 mon_got.d, mon_got.p, mon_got.f, mon_got.b, mon_got.o);
      end else begin
        mon_want = sb.pop_front();
        if (mon_got !== mon_want) begin
          errors++;
          $display("FAIL word got data=%h p%b f%b b%b o%b required data=%h p%b f%b b%b o%b",
                   mon_got.d, mon_got.p, mon_got.f, mon_got.b, mon_got.o,
                   mon_want.d, mon_want.p, mon_want.f, mon_want.b, mon_want.o);
        end
      end
    end
  end

  function automatic logic even_bit(input logic [8:0] d, input int nb);
    logic x = 1'b0;
    for (int i = 0; i < nb; i++) x ^= d[i];
    return x;
  endfunction

  task automatic line(input logic v, input int clks);
    rx_i = v;
    repeat (clks) @(negedge clk);
  endtask

  task automatic send_frame(input logic [8:0] d, input int nb, input bit has_par,
                            input logic pbit, input int nstop, input logic stop_last);
    line(1'b0, BT);
    for (int i = 0; i < nb; i++) line(d[i], BT);
    if (has_par) line(pbit, BT);
    for (int s = 0; s < nstop; s++) line((s == nstop - 1) ? stop_last : 1'b1, BT);
    line(1'b1, 2 * BT);
  endtask

  task automatic test_reset;
    rst = 1'b1; rx_i = 1'b1; rx_if.rx_ready = 1'b1;
    cfg_bits = 4'd8; cfg_par = 3'd0; cfg_stop2 = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (rx_if.rx_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid got=%b required=0", rx_if.rx_valid);
    end
    checks++;
    if ({rx_if.rx_data, rx_if.rx_par_err, rx_if.rx_frm_err, rx_if.rx_brk, rx_if.rx_ovr} !== 13'd0) begin
      errors++; $display("FAIL reset_outputs got data=%h flags=%b%b%b%b required all 0", rx_if.rx_data,
                         rx_if.rx_par_err, rx_if.rx_frm_err, rx_if.rx_brk, rx_if.rx_ovr);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy got=%b required=0", busy);
    end
  endtask

  task automatic test_8n1;
    cfg_bits = 4'd8; cfg_par = 3'd0; cfg_stop2 = 1'b0;
    sb.push_back('{d: 9'h0A5, p: 0, f: 0, b: 0, o: 0});
    send_frame(9'h0A5, 8, 0, 1'b0, 1, 1'b1);
    sb.push_back('{d: 9'h05A, p: 0, f: 0, b: 0, o: 0});
    send_frame(9'h05A, 8, 0, 1'b0, 1, 1'b1);
    // width below 5 is widened to 5
    cfg_bits = 4'd3;
    sb.push_back('{d: 9'h015, p: 0, f: 0, b: 0, o: 0});
    send_frame(9'h015, 5, 0, 1'b0, 1, 1'b1);
    for (int i = 0; i < TMO && sb.size() != 0; i++) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL 8n1_timeout pending=%0d required=0", sb.size()); sb.delete();
    end
  endtask

  task automatic test_parity;
    cfg_bits = 4'd7; cfg_par = 3'd1; cfg_stop2 = 1'b0;
    sb.push_back('{d: 9'h035, p: 1, f: 0, b: 0, o: 0});
    send_frame(9'h035, 7, 1, 1'b1, 1, 1'b1);
    cfg_bits = 4'd8; cfg_par = 3'd2;
    sb.push_back('{d: 9'h03C, p: 0, f: 0, b: 0, o: 0});
    send_frame(9'h03C, 8, 1, ~even_bit(9'h03C, 8), 1, 1'b1);
    cfg_par = 3'd3;
    sb.push_back('{d: 9'h05A, p: 1, f: 0, b: 0, o: 0});
    send_frame(9'h05A, 8, 1, 1'b0, 1, 1'b1);
    // mode 6 means no parity bit at all
    cfg_par = 3'd6;
    sb.push_back('{d: 9'h00F, p: 0, f: 0, b: 0, o: 0});
    send_frame(9'h00F, 8, 0, 1'b0, 1, 1'b1);
    cfg_par = 3'd0;
    for (int i = 0; i < TMO && sb.size() != 0; i++) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL parity_timeout pending=%0d required=0", sb.size()); sb.delete();
    end
  endtask

  task automatic test_false_start;
    cfg_bits = 4'd8; cfg_par = 3'd0;
    line(1'b0, 4 * BDIV);
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL false_start_busy_high got=%b required=1", busy);
    end
    line(1'b1, 2 * BT);
    checks++;
    if (busy !== 1'b0 || rx_if.rx_valid !== 1'b0) begin
      errors++; $display("FAIL false_start_idle got busy=%b valid=%b required 0 0", busy, rx_if.rx_valid);
    end
    // 0x00 with a one-tick high glitch in the middle of data bit 3
    sb.push_back('{d: 9'h000, p: 0, f: 0, b: 0, o: 0});
    line(1'b0, BT);
    line(1'b0, 3 * BT);
    line(1'b0, 8 * BDIV);
    line(1'b1, BDIV);
    line(1'b0, BT - 9 * BDIV);
    line(1'b0, 4 * BT);
    line(1'b1, BT);
    line(1'b1, 2 * BT);
    for (int i = 0; i < TMO && sb.size() != 0; i++) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL glitch_timeout pending=%0d required=0", sb.size()); sb.delete();
    end
  endtask

  task automatic test_break;
    cfg_bits = 4'd8; cfg_par = 3'd0; cfg_stop2 = 1'b0;
    sb.push_back('{d: 9'h000, p: 0, f: 1, b: 1, o: 0});
    line(1'b0, 20 * BT);
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL break_busy got=%b required=1", busy);
    end
    line(1'b1, 2 * BT);
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL break_exit_busy got=%b required=0", busy);
    end
    sb.push_back('{d: 9'h03C, p: 0, f: 0, b: 0, o: 0});
    send_frame(9'h03C, 8, 0, 1'b0, 1, 1'b1);
    for (int i = 0; i < TMO && sb.size() != 0; i++) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL break_timeout pending=%0d required=0", sb.size()); sb.delete();
    end
  endtask

  task automatic test_overrun;
    cfg_bits = 4'd8; cfg_par = 3'd0; cfg_stop2 = 1'b0;
    @(posedge clk); #2;
    rx_if.rx_ready = 1'b0;
    sb.push_back('{d: 9'h011, p: 0, f: 0, b: 0, o: 1});
    send_frame(9'h011, 8, 0, 1'b0, 1, 1'b1);
    send_frame(9'h022, 8, 0, 1'b0, 1, 1'b1);
    checks++;
    if (rx_if.rx_valid !== 1'b1 || rx_if.rx_data !== 9'h011 || rx_if.rx_ovr !== 1'b1) begin
      errors++; $display("FAIL overrun_hold got valid=%b data=%h ovr=%b required 1 011 1",
                         rx_if.rx_valid, rx_if.rx_data, rx_if.rx_ovr);
    end
    @(posedge clk); #2;
    rx_if.rx_ready = 1'b1;
    for (int i = 0; i < TMO && sb.size() != 0; i++) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL overrun_timeout pending=%0d required=0", sb.size()); sb.delete();
    end
    @(negedge clk);
    checks++;
    if (rx_if.rx_valid !== 1'b0 || rx_if.rx_ovr !== 1'b0) begin
      errors++; $display("FAIL overrun_accept got valid=%b ovr=%b required 0 0", rx_if.rx_valid, rx_if.rx_ovr);
    end
  endtask

  task automatic test_stop2_and_reset;
    cfg_bits = 4'd9; cfg_par = 3'd0; cfg_stop2 = 1'b1;
    sb.push_back('{d: 9'h1FF, p: 0, f: 1, b: 0, o: 0});
    send_frame(9'h1FF, 9, 0, 1'b0, 2, 1'b0);
    for (int i = 0; i < TMO && sb.size() != 0; i++) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL stop2_timeout pending=%0d required=0", sb.size()); sb.delete();
    end
    // 0xF0, reset pulsed in the middle of data bit 4 (high from there on)
    cfg_bits = 4'd8; cfg_stop2 = 1'b0;
    line(1'b0, BT);
    line(1'b0, 4 * BT);
    line(1'b1, BT / 2);
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL midframe_busy got=%b required=1", busy);
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    line(1'b1, 6 * BT);
    checks++;
    if (rx_if.rx_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL midframe_reset got valid=%b busy=%b required 0 0", rx_if.rx_valid, busy);
    end
  endtask

  initial begin
    test_reset;
    test_8n1;
    test_parity;
    test_false_start;
    test_break;
    test_overrun;
    test_stop2_and_reset;
    repeat (10) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
